// File: rtl/button_event_gen.sv
// Per-channel press/release/long-press/auto-repeat pulse generator.
// Fed by clean debounced levels; every output is registered.
//
// state  | meaning
// IDLE   | input low, waiting for a press
// PRESS  | input high, counting towards the long-press hold time
// REPEAT | hold time elapsed, emitting periodic repeat pulses

module button_event_gen #(
    parameter int WIDTH         = 1,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CNT_WIDTH     = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        state_t               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 press_q, press_d;
        logic                 release_q, release_d;
        logic                 long_q, long_d;
        logic                 repeat_q, repeat_d;
        logic                 held_q, held_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
                held_q    <= held_d;
            end
        end

        // Release is tested first so it wins over a long/repeat firing on the same edge.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            repeat_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (debounced_signal[g]) begin
                        state_d = PRESS;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                PRESS: begin
                    if (!debounced_signal[g]) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!debounced_signal[g]) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end else if (cnt_q == REPEAT_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            held_d = (state_d == REPEAT);
        end

        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign long_press[g]    = long_q;
        assign repeat_pulse[g]  = repeat_q;
        assign held[g]          = held_q;
    end

endmodule
